// File: rtl/note_detector.sv
// note_detector: measures the half-period of a square wave and decodes it to (note, octave).
// Optional NOTE_DET_HYST_EN: a matched decode is reported only when it repeats the previous one.
module note_detector #(
  parameter int unsigned OFF_LIMIT = 370000,
  parameter int unsigned TOL_SHIFT = 6
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        audio_in,
  output logic        valid,
  output logic [3:0]  note,
  output logic [2:0]  octave,
  output logic [18:0] err,
  output logic        matched,
  output logic        busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [18:0] OFF_L = 19'(OFF_LIMIT);

  // Octave-0 half-periods in clk cycles, indexed by note 1..12.
  function automatic logic [18:0] base_of(input logic [3:0] n);
    logic [18:0] b;
    unique case (n)
      4'd1:    b = 19'd366937;
      4'd2:    b = 19'd346342;
      4'd3:    b = 19'd326903;
      4'd4:    b = 19'd308556;
      4'd5:    b = 19'd291238;
      4'd6:    b = 19'd274892;
      4'd7:    b = 19'd259463;
      4'd8:    b = 19'd244901;
      4'd9:    b = 19'd231156;
      4'd10:   b = 19'd218182;
      4'd11:   b = 19'd205936;
      4'd12:   b = 19'd194378;
      default: b = 19'd0;
    endcase
    return b;
  endfunction

  logic        sync1_q, sync2_q, prev_q;
  logic        edge_det, timeout;
  logic [18:0] cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic [1:0]  state_q, state_d;
  logic [18:0] meas_q, meas_d;
  logic [2:0]  oct_q, oct_d;
  logic [3:0]  nte_q, nte_d;
  logic [3:0]  bnote_q, bnote_d;
  logic [2:0]  boct_q, boct_d;
  logic [18:0] bdiff_q, bdiff_d;
  logic [3:0]  note_q, note_d;
  logic [2:0]  octave_q, octave_d;
  logic [18:0] err_q, err_d;
  logic        matched_q, matched_d;
  logic [18:0] cand, diff;
  logic        hit, pass, fire;
  logic [3:0]  dec_note;
  logic [2:0]  dec_oct;
`ifdef NOTE_DET_HYST_EN
  logic [3:0]  pnote_q, pnote_d;
  logic [2:0]  poct_q, poct_d;
`endif

  assign edge_det = sync2_q ^ prev_q;
  assign timeout  = armed_q && !edge_det
                    && (cnt_q == OFF_L);

  // Candidate distance and final decode of the best candidate.
  always_comb begin
    cand     = base_of(nte_q) >> oct_q;
    diff     = (cand >= meas_q) ? cand - meas_q
                                : meas_q - cand;
    hit      = bdiff_q <= (meas_q >> TOL_SHIFT);
    dec_note = hit ? bnote_q : 4'd0;
    dec_oct  = hit ? boct_q : 3'd0;
`ifdef NOTE_DET_HYST_EN
    pass     = !hit || ((bnote_q == pnote_q)
                        && (boct_q == poct_q));
`else
    pass     = 1'b1;
`endif
    fire     = (state_q == S_DONE) && !timeout && pass;
  end

  // Half-period counter and arming; a timeout disarms.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (edge_det) begin
      cnt_d   = 19'd1;
      armed_d = 1'b1;
    end else if (timeout) begin
      cnt_d   = 19'd0;
      armed_d = 1'b0;
    end else if (armed_q) begin
      cnt_d = cnt_q + 19'd1;
    end
  end

  // Search FSM: one candidate per cycle, octave outer, note inner.
  always_comb begin
    state_d = state_q;
    meas_d  = meas_q;
    oct_d   = oct_q;
    nte_d   = nte_q;
    bnote_d = bnote_q;
    boct_d  = boct_q;
    bdiff_d = bdiff_q;
    if (timeout) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (edge_det && armed_q) begin
            state_d = S_SEARCH;
            meas_d  = cnt_q;
            oct_d   = 3'd0;
            nte_d   = 4'd1;
            bnote_d = 4'd0;
            boct_d  = 3'd0;
            bdiff_d = '1;
          end
        end
        S_SEARCH: begin
          if (diff < bdiff_q) begin
            bnote_d = nte_q;
            boct_d  = oct_q;
            bdiff_d = diff;
          end
          if (nte_q == 4'd12) begin
            nte_d = 4'd1;
            oct_d = oct_q + 3'd1;
            if (oct_q == 3'd7) state_d = S_DONE;
          end else begin
            nte_d = nte_q + 4'd1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Held decode outputs; the next value is also what is driven out.
  always_comb begin
    note_d    = note_q;
    octave_d  = octave_q;
    err_d     = err_q;
    matched_d = matched_q;
    if (timeout) begin
      note_d    = 4'd0;
      octave_d  = 3'd0;
      err_d     = 19'd0;
      matched_d = 1'b0;
    end else if (fire) begin
      note_d    = dec_note;
      octave_d  = dec_oct;
      err_d     = bdiff_q;
      matched_d = hit;
    end
  end

`ifdef NOTE_DET_HYST_EN
  // Remember the last matched decode; silence forgets it.
  always_comb begin
    pnote_d = pnote_q;
    poct_d  = poct_q;
    if (timeout) begin
      pnote_d = 4'd0;
      poct_d  = 3'd0;
    end else if (state_q == S_DONE && hit) begin
      pnote_d = bnote_q;
      poct_d  = boct_q;
    end
  end

  // Previous-decode register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pnote_q <= 4'd0;
      poct_q  <= 3'd0;
    end else begin
      pnote_q <= pnote_d;
      poct_q  <= poct_d;
    end
  end
`endif

  // State registers, synchronizer and edge history.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      cnt_q     <= 19'd0;
      armed_q   <= 1'b0;
      state_q   <= S_IDLE;
      meas_q    <= 19'd0;
      oct_q     <= 3'd0;
      nte_q     <= 4'd1;
      bnote_q   <= 4'd0;
      boct_q    <= 3'd0;
      bdiff_q   <= '1;
      note_q    <= 4'd0;
      octave_q  <= 3'd0;
      err_q     <= 19'd0;
      matched_q <= 1'b0;
    end else begin
      sync1_q   <= audio_in;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      state_q   <= state_d;
      meas_q    <= meas_d;
      oct_q     <= oct_d;
      nte_q     <= nte_d;
      bnote_q   <= bnote_d;
      boct_q    <= boct_d;
      bdiff_q   <= bdiff_d;
      note_q    <= note_d;
      octave_q  <= octave_d;
      err_q     <= err_d;
      matched_q <= matched_d;
    end
  end

  assign valid   = timeout | fire;
  assign note    = note_d;
  assign octave  = octave_d;
  assign err     = err_d;
  assign matched = matched_d;
  assign busy    = (state_q == S_SEARCH)
                   || (state_q == S_DONE);

endmodule

// File: tb/tb_note_detector.sv
// tb_note_detector: directed checks of note_detector.
// Silence limit shortened to keep the run small; HYST mirrors NOTE_DET_HYST_EN.
`timescale 1ns/1ps
module tb_note_detector;

  localparam int unsigned OFF = 10000;
`ifdef NOTE_DET_HYST_EN
  localparam bit HYST = 1'b1;
`else
  localparam bit HYST = 1'b0;
`endif

  localparam logic [26:0] Z27  = 27'd0;
  localparam logic [26:0] A7   = {4'd10, 3'd7, 19'd0, 1'b1};
  localparam logic [26:0] A7E  = {4'd10, 3'd7, 19'd16, 1'b1};
  localparam logic [26:0] NM45 = {4'd0, 3'd0, 19'd45, 1'b0};
  localparam logic [26:0] B6   = {4'd12, 3'd6, 19'd0, 1'b1};
  localparam logic [26:0] C7   = {4'd1, 3'd7, 19'd0, 1'b1};
  localparam logic [26:0] G7   = {4'd8, 3'd7, 19'd0, 1'b1};

  logic        clk = 1'b0;
  logic        n_rst;
  logic        audio_in;
  logic        valid;
  logic [3:0]  note;
  logic [2:0]  octave;
  logic [18:0] err;
  logic        matched;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  int          obs_cnt, obs_idx;
  logic [26:0] obs_out;
  logic        obs_bmid, obs_bend;
  logic [26:0] now_out;
  int          exp_cnt;

  note_detector #(
    .OFF_LIMIT(OFF),
    .TOL_SHIFT(6)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .audio_in(audio_in),
    .valid(valid),
    .note(note),
    .octave(octave),
    .err(err),
    .matched(matched),
    .busy(busy)
  );

  always #5 clk = ~clk;

  assign now_out = {note, octave, err, matched};

  task automatic observe(input int n);
    obs_cnt  = 0;
    obs_idx  = -1;
    obs_out  = '0;
    obs_bmid = 1'b0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (i == 50) obs_bmid = busy;
      if (valid === 1'b1) begin
        if (obs_cnt == 0) begin
          obs_idx = i;
          obs_out = now_out;
        end
        obs_cnt++;
      end
    end
    obs_bend = busy;
  endtask

  task automatic step(input int p);
    audio_in = ~audio_in;
    observe(p);
  endtask

  task automatic test_reset;
    n_rst    = 1'b0;
    audio_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({valid, now_out, busy} !== 29'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0",
               {valid, now_out, busy});
    end
    n_rst = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_lock;
    step(1704);
    checks++;
    if (obs_cnt !== 0 || obs_bmid !== 1'b0) begin
      errors++;
      $display("FAIL arm_edge: valids=%0d busy=%b want 0/0",
               obs_cnt, obs_bmid);
    end
    step(1704);
    exp_cnt = HYST ? 0 : 1;
    checks++;
    if (obs_cnt !== exp_cnt || now_out !== (HYST ? Z27 : A7)) begin
      errors++;
      $display("FAIL first_A7: valids=%0d out=%h want %0d/%h",
               obs_cnt, now_out, exp_cnt, HYST ? Z27 : A7);
    end
    step(1704);
    checks++;
    if (obs_cnt !== 1 || obs_idx !== 99) begin
      errors++;
      $display("FAIL lock_latency: valids=%0d at %0d want 1 at 99",
               obs_cnt, obs_idx);
    end
    checks++;
    if (obs_out !== A7) begin
      errors++;
      $display("FAIL lock_A7: got %h want %h", obs_out, A7);
    end
    checks++;
    if (obs_bmid !== 1'b1 || obs_bend !== 1'b0) begin
      errors++;
      $display("FAIL lock_busy: mid=%b end=%b want 1/0",
               obs_bmid, obs_bend);
    end
    step(1720);
    checks++;
    if (obs_cnt !== 1 || obs_out !== A7) begin
      errors++;
      $display("FAIL lock_again: valids=%0d out=%h want 1/%h",
               obs_cnt, obs_out, A7);
    end
  endtask

  task automatic test_tolerance;
    step(1760);
    checks++;
    if (obs_cnt !== 1 || obs_out !== A7E) begin
      errors++;
      $display("FAIL offset_1720: valids=%0d out=%h want 1/%h",
               obs_cnt, obs_out, A7E);
    end
    step(3037);
    checks++;
    if (obs_cnt !== 1 || obs_out !== NM45) begin
      errors++;
      $display("FAIL nomatch_1760: valids=%0d out=%h want 1/%h",
               obs_cnt, obs_out, NM45);
    end
  endtask

  task automatic test_bounds;
    step(3037);
    exp_cnt = HYST ? 0 : 1;
    checks++;
    if (obs_cnt !== exp_cnt || now_out !== (HYST ? NM45 : B6)) begin
      errors++;
      $display("FAIL first_B6: valids=%0d out=%h want %0d/%h",
               obs_cnt, now_out, exp_cnt, HYST ? NM45 : B6);
    end
    step(2866);
    checks++;
    if (obs_cnt !== 1 || obs_out !== B6) begin
      errors++;
      $display("FAIL B6: valids=%0d out=%h want 1/%h",
               obs_cnt, obs_out, B6);
    end
    step(2866);
    checks++;
    if (obs_cnt !== exp_cnt || now_out !== (HYST ? B6 : C7)) begin
      errors++;
      $display("FAIL first_C7: valids=%0d out=%h want %0d/%h",
               obs_cnt, now_out, exp_cnt, HYST ? B6 : C7);
    end
    step(1913);
    checks++;
    if (obs_cnt !== 1 || obs_out !== C7) begin
      errors++;
      $display("FAIL C7: valids=%0d out=%h want 1/%h",
               obs_cnt, obs_out, C7);
    end
    checks++;
    if (now_out !== C7) begin
      errors++;
      $display("FAIL hold_C7: got %h want %h", now_out, C7);
    end
  endtask

  task automatic test_timeout;
    step(200);
    exp_cnt = HYST ? 0 : 1;
    checks++;
    if (obs_cnt !== exp_cnt || now_out !== (HYST ? C7 : G7)) begin
      errors++;
      $display("FAIL first_G7: valids=%0d out=%h want %0d/%h",
               obs_cnt, now_out, exp_cnt, HYST ? C7 : G7);
    end
    observe(12000);
    checks++;
    if (obs_cnt !== 1 || obs_idx !== 9802) begin
      errors++;
      $display("FAIL timeout_pulse: valids=%0d at %0d want 1 at 9802",
               obs_cnt, obs_idx);
    end
    checks++;
    if (obs_out !== Z27 || obs_bend !== 1'b0) begin
      errors++;
      $display("FAIL timeout_out: out=%h busy=%b want 0/0",
               obs_out, obs_bend);
    end
    step(1913);
    checks++;
    if (obs_cnt !== 0) begin
      errors++;
      $display("FAIL rearm_edge: valids=%0d want 0", obs_cnt);
    end
    step(1913);
    checks++;
    if (obs_cnt !== exp_cnt || now_out !== (HYST ? Z27 : G7)) begin
      errors++;
      $display("FAIL rearm_G7: valids=%0d out=%h want %0d/%h",
               obs_cnt, now_out, exp_cnt, HYST ? Z27 : G7);
    end
    step(200);
    checks++;
    if (obs_cnt !== 1 || obs_out !== G7) begin
      errors++;
      $display("FAIL repeat_G7: valids=%0d out=%h want 1/%h",
               obs_cnt, obs_out, G7);
    end
  endtask

  task automatic test_reset_search;
    step(42);
    checks++;
    if (obs_cnt !== 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_abort: valids=%0d busy=%b want 0/1",
               obs_cnt, busy);
    end
    n_rst = 1'b0;
    #1;
    checks++;
    if ({valid, now_out, busy} !== 29'd0) begin
      errors++;
      $display("FAIL abort_outputs: got %h want 0",
               {valid, now_out, busy});
    end
    audio_in = 1'b0;
    observe(150);
    checks++;
    if (obs_cnt !== 0 || obs_bend !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet: valids=%0d busy=%b want 0/0",
               obs_cnt, obs_bend);
    end
    n_rst = 1'b1;
    observe(20);
    step(1704);
    checks++;
    if (obs_cnt !== 0) begin
      errors++;
      $display("FAIL post_rst_arm: valids=%0d want 0", obs_cnt);
    end
    step(1704);
    exp_cnt = HYST ? 0 : 1;
    checks++;
    if (obs_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL post_rst_first: valids=%0d want %0d",
               obs_cnt, exp_cnt);
    end
    step(300);
    checks++;
    if (obs_cnt !== 1 || obs_out !== A7) begin
      errors++;
      $display("FAIL post_rst_A7: valids=%0d out=%h want 1/%h",
               obs_cnt, obs_out, A7);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_tolerance();
    test_bounds();
    test_timeout();
    test_reset_search();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
